// File: rtl/readout_rx_pkg.sv
// ----------------------------------------------------------------------------
// readout_rx_pkg
//   Shared types and constants for the readout RX state-decision logic.
//   - ch_state_e : per-channel decision state (IDLE, ACTIVE, PEND)
//   - THR_*_FIELD: field index of each threshold inside a threshold memory
//                  word; a field occupies [idx*THRESHOLD_WIDTH +: THRESHOLD_WIDTH]
//   - thr_field_lsb(): LSB position of a field for a given threshold width
// ----------------------------------------------------------------------------
package readout_rx_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        PEND   = 2'd2
    } ch_state_e;

    // Memory word layout: {upper, lower}
    localparam int THR_LOWER_FIELD = 0;
    localparam int THR_UPPER_FIELD = 1;

    function automatic int thr_field_lsb(input int field, input int width);
        return field * width;
    endfunction

endpackage

// File: rtl/readout_rx_decision_channel_fsm.sv
// ----------------------------------------------------------------------------
// readout_rx_decision_channel_fsm
//   One readout channel: adaptive multi-trial |0>/|1> decision.
//   On each finish_trial in ACTIVE the bin count is compared against the
//   threshold pair of the current trial; the channel either decides (and
//   parks the result in PEND until the arbiter drains it) or moves to the
//   next trial. The last allowed trial forces a decision against a fixed
//   fallback threshold.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   start           pulse: begin (or restart) a measurement
//   finish_trial    pulse: bin_count of the current trial is valid
//   bin_count       unsigned bin count of the current trial
//   thr_upper/lower threshold pair read at address trial_cnt
//   max_trial_cfg   last trial index
//   grant           result of this channel accepted on the result port
//   trial_cnt       current trial index (also the threshold read address
//                   and, while pending, the decided trial index)
//   pend            a decided result is waiting to be drained
//   result_state    decided state, valid while pend
//   decision_fin    combinational pulse: decided this cycle
//   overrun         sticky: finish_trial arrived while result was pending
// ----------------------------------------------------------------------------
module readout_rx_decision_channel_fsm
    import readout_rx_pkg::*;
#(
    parameter int BIN_COUNTER_WIDTH  = 16,
    parameter int THRESHOLD_WIDTH    = 16,
    parameter int TRIAL_WIDTH        = 4,
    parameter int FALLBACK_THRESHOLD = 32768
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         finish_trial,
    input  logic [BIN_COUNTER_WIDTH-1:0] bin_count,
    input  logic [THRESHOLD_WIDTH-1:0]   thr_upper,
    input  logic [THRESHOLD_WIDTH-1:0]   thr_lower,
    input  logic [TRIAL_WIDTH-1:0]       max_trial_cfg,
    input  logic                         grant,
    output logic [TRIAL_WIDTH-1:0]       trial_cnt,
    output logic                         pend,
    output logic                         result_state,
    output logic                         decision_fin,
    output logic                         overrun
);

    localparam logic [BIN_COUNTER_WIDTH-1:0] FALLBACK_VALUE =
        BIN_COUNTER_WIDTH'(FALLBACK_THRESHOLD);

    ch_state_e                state, state_next;
    logic [TRIAL_WIDTH-1:0]   trial_cnt_next;
    logic                     result_next;
    logic                     overrun_next;
    logic                     above_upper;
    logic                     below_lower;
    logic                     last_trial;
    logic                     decided;
    logic                     evaluate;

    assign above_upper = (bin_count >= thr_upper);
    assign below_lower = (bin_count < thr_lower);
    // ">=" rather than "==": if max_trial_cfg is lowered mid-measurement the
    // channel may already be past it and must decide on this trial.
    assign last_trial  = (trial_cnt >= max_trial_cfg);
    assign decided     = last_trial | above_upper | below_lower;
    // A start in the same cycle restarts the measurement and suppresses
    // evaluation of the finishing trial.
    assign evaluate    = (state == ACTIVE) & finish_trial & ~start;

    assign decision_fin = evaluate & decided;
    assign pend         = (state == PEND);

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            trial_cnt    <= '0;
            result_state <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            state        <= state_next;
            trial_cnt    <= trial_cnt_next;
            result_state <= result_next;
            overrun      <= overrun_next;
        end
    end

    // NOTE: every variable gets a hold value before the case statement so
    // that no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next     = state;
        trial_cnt_next = trial_cnt;
        result_next    = result_state;
        overrun_next   = overrun;

        unique case (state)
            IDLE: begin
                if (start) begin
                    state_next     = ACTIVE;
                    trial_cnt_next = '0;
                end
            end
            ACTIVE: begin
                if (start) begin
                    trial_cnt_next = '0;
                end else if (finish_trial) begin
                    if (decided) begin
                        state_next  = PEND;
                        // Forced last-trial decision overrides both thresholds;
                        // otherwise upper wins over lower when they overlap.
                        result_next = last_trial ? (bin_count >= FALLBACK_VALUE)
                                                 : above_upper;
                    end else begin
                        trial_cnt_next = trial_cnt + TRIAL_WIDTH'(1);
                    end
                end
            end
            PEND: begin
                // trial_cnt holds the decided trial index until drained;
                // a start here is deliberately dropped.
                if (finish_trial) begin
                    overrun_next = 1'b1;
                end
                if (grant) begin
                    state_next     = IDLE;
                    trial_cnt_next = '0;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: rtl/readout_rx_state_decision_multi_channel.sv
// ----------------------------------------------------------------------------
// readout_rx_state_decision_multi_channel
//   Multi-channel state-decision stage after the readout RX bin counters.
//   Holds the shared per-trial threshold memory, one decision FSM per
//   channel, and a round-robin arbiter that drains decided results over a
//   single valid/ready port.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   thr_wr_en/addr/data  threshold memory write port, data = {upper, lower}
//   max_trial_cfg        last trial index (trials allowed = cfg+1)
//   start_in             per-channel measurement start pulse
//   finish_trial_in      per-channel "bin count valid" pulse
//   bin_count_in         channel c at [c*BIN_COUNTER_WIDTH +: BIN_COUNTER_WIDTH]
//   decision_fin_out     per-channel combinational "decided now" pulse
//   result_valid_out     a result is presented
//   result_ready_in      consumer accepts the presented result
//   result_channel_out   channel id of the presented result
//   result_state_out     decided state of the presented result
//   result_trials_out    trial index at which the decision was made
//   overrun_out          per-channel sticky finish-while-pending flag
// ----------------------------------------------------------------------------
module readout_rx_state_decision_multi_channel
    import readout_rx_pkg::*;
#(
    parameter int NUM_CHANNEL        = 4,
    parameter int BIN_COUNTER_WIDTH  = 16,
    parameter int THRESHOLD_WIDTH    = 16,
    parameter int TRIAL_WIDTH        = 4,
    parameter int CH_ID_WIDTH        = 2,
    parameter int FALLBACK_THRESHOLD = 32768
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   thr_wr_en,
    input  logic [TRIAL_WIDTH-1:0]                 thr_wr_addr,
    input  logic [2*THRESHOLD_WIDTH-1:0]           thr_wr_data,
    input  logic [TRIAL_WIDTH-1:0]                 max_trial_cfg,
    input  logic [NUM_CHANNEL-1:0]                 start_in,
    input  logic [NUM_CHANNEL-1:0]                 finish_trial_in,
    input  logic [NUM_CHANNEL*BIN_COUNTER_WIDTH-1:0] bin_count_in,
    output logic [NUM_CHANNEL-1:0]                 decision_fin_out,
    output logic                                   result_valid_out,
    input  logic                                   result_ready_in,
    output logic [CH_ID_WIDTH-1:0]                 result_channel_out,
    output logic                                   result_state_out,
    output logic [TRIAL_WIDTH-1:0]                 result_trials_out,
    output logic [NUM_CHANNEL-1:0]                 overrun_out
);

    localparam int DEPTH      = 2**TRIAL_WIDTH;
    localparam int WORD_WIDTH = 2*THRESHOLD_WIDTH;
    localparam int UPPER_LSB  = thr_field_lsb(THR_UPPER_FIELD, THRESHOLD_WIDTH);
    localparam int LOWER_LSB  = thr_field_lsb(THR_LOWER_FIELD, THRESHOLD_WIDTH);

    if (BIN_COUNTER_WIDTH != THRESHOLD_WIDTH) begin : g_width_check
        $error("BIN_COUNTER_WIDTH must equal THRESHOLD_WIDTH");
    end
    if ((2**CH_ID_WIDTH) < NUM_CHANNEL) begin : g_ch_id_check
        $error("CH_ID_WIDTH too narrow for NUM_CHANNEL");
    end

    // ------------------------------------------------------------------
    // Threshold memory: one write port, one combinational read per channel.
    // A same-cycle write and read of an entry returns the old word.
    // ------------------------------------------------------------------
    logic [WORD_WIDTH-1:0] thr_mem [DEPTH];

    // NOTE: the threshold array has no reset; software reloads it, and
    // leaving it unreset keeps it a plain register file without a reset tree.
    always_ff @(posedge clk) begin
        if (thr_wr_en) begin
            thr_mem[thr_wr_addr] <= thr_wr_data;
        end
    end

    // ------------------------------------------------------------------
    // Per-channel decision FSMs
    // ------------------------------------------------------------------
    logic [TRIAL_WIDTH-1:0] trial_cnt [NUM_CHANNEL];
    logic [NUM_CHANNEL-1:0] pend;
    logic [NUM_CHANNEL-1:0] result_state;
    logic [NUM_CHANNEL-1:0] grant_vec;

    for (genvar c = 0; c < NUM_CHANNEL; c++) begin : g_ch
        logic [WORD_WIDTH-1:0] thr_word;

        assign thr_word = thr_mem[trial_cnt[c]];

        readout_rx_decision_channel_fsm #(
            .BIN_COUNTER_WIDTH  (BIN_COUNTER_WIDTH),
            .THRESHOLD_WIDTH    (THRESHOLD_WIDTH),
            .TRIAL_WIDTH        (TRIAL_WIDTH),
            .FALLBACK_THRESHOLD (FALLBACK_THRESHOLD)
        ) u_fsm (
            .clk           (clk),
            .rst           (rst),
            .start         (start_in[c]),
            .finish_trial  (finish_trial_in[c]),
            .bin_count     (bin_count_in[c*BIN_COUNTER_WIDTH +: BIN_COUNTER_WIDTH]),
            .thr_upper     (thr_word[UPPER_LSB +: THRESHOLD_WIDTH]),
            .thr_lower     (thr_word[LOWER_LSB +: THRESHOLD_WIDTH]),
            .max_trial_cfg (max_trial_cfg),
            .grant         (grant_vec[c]),
            .trial_cnt     (trial_cnt[c]),
            .pend          (pend[c]),
            .result_state  (result_state[c]),
            .decision_fin  (decision_fin_out[c]),
            .overrun       (overrun_out[c])
        );
    end

    // ------------------------------------------------------------------
    // Round-robin arbiter. Once a result is presented without ready, the
    // grant is frozen (hold) so a newly pending channel that ranks earlier
    // cannot change the outputs under a waiting consumer.
    // ------------------------------------------------------------------
    logic [CH_ID_WIDTH-1:0] rr_ptr;
    logic [CH_ID_WIDTH-1:0] hold_idx;
    logic                   hold_active;
    logic [CH_ID_WIDTH-1:0] scan_idx;
    logic [CH_ID_WIDTH-1:0] grant_idx;
    logic                   any_pend;
    logic                   handshake;

    always_comb begin
        grant_idx = '0;
        any_pend  = 1'b0;
        scan_idx  = '0;
        for (int i = 0; i < NUM_CHANNEL; i++) begin
            scan_idx = CH_ID_WIDTH'((int'(rr_ptr) + i) % NUM_CHANNEL);
            if (!any_pend && pend[scan_idx]) begin
                any_pend  = 1'b1;
                grant_idx = scan_idx;
            end
        end
        if (hold_active) begin
            grant_idx = hold_idx;
        end
    end

    assign handshake = result_valid_out & result_ready_in;
    assign grant_vec = handshake ? (NUM_CHANNEL'(1) << grant_idx) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr      <= '0;
            hold_active <= 1'b0;
            hold_idx    <= '0;
        end else if (handshake) begin
            rr_ptr      <= CH_ID_WIDTH'((int'(grant_idx) + 1) % NUM_CHANNEL);
            hold_active <= 1'b0;
        end else if (result_valid_out) begin
            hold_active <= 1'b1;
            hold_idx    <= grant_idx;
        end
    end

    // Result port is forced to zero while nothing is presented.
    assign result_valid_out   = any_pend;
    assign result_channel_out = any_pend ? grant_idx : '0;
    assign result_state_out   = any_pend & result_state[grant_idx];
    assign result_trials_out  = any_pend ? trial_cnt[grant_idx] : '0;

endmodule

// File: tb/tb_readout_rx_state_decision_multi_channel.sv
// ----------------------------------------------------------------------------
// tb_readout_rx_state_decision_multi_channel
//   Directed bench: expected results are queued when a deciding
//   finish_trial is driven and popped/compared by a monitor whenever a
//   result is handed over (valid & ready, sampled on the falling edge).
// ----------------------------------------------------------------------------
module tb_readout_rx_state_decision_multi_channel;

    localparam int NCH = 4;
    localparam int BCW = 16;
    localparam int TW  = 4;
    localparam int CHW = 2;

    typedef struct packed {
        logic [CHW-1:0] ch;
        logic           st;
        logic [TW-1:0]  tr;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst;
    logic               thr_wr_en;
    logic [TW-1:0]      thr_wr_addr;
    logic [2*BCW-1:0]   thr_wr_data;
    logic [TW-1:0]      max_trial_cfg;
    logic [NCH-1:0]     start_in;
    logic [NCH-1:0]     finish_trial_in;
    logic [NCH*BCW-1:0] bin_count_in;
    logic [NCH-1:0]     decision_fin_out;
    logic               result_valid_out;
    logic               result_ready_in;
    logic [CHW-1:0]     result_channel_out;
    logic               result_state_out;
    logic [TW-1:0]      result_trials_out;
    logic [NCH-1:0]     overrun_out;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb_q[$];

    readout_rx_state_decision_multi_channel #(
        .NUM_CHANNEL        (NCH),
        .BIN_COUNTER_WIDTH  (BCW),
        .THRESHOLD_WIDTH    (BCW),
        .TRIAL_WIDTH        (TW),
        .CH_ID_WIDTH        (CHW),
        .FALLBACK_THRESHOLD (32768)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .thr_wr_en          (thr_wr_en),
        .thr_wr_addr        (thr_wr_addr),
        .thr_wr_data        (thr_wr_data),
        .max_trial_cfg      (max_trial_cfg),
        .start_in           (start_in),
        .finish_trial_in    (finish_trial_in),
        .bin_count_in       (bin_count_in),
        .decision_fin_out   (decision_fin_out),
        .result_valid_out   (result_valid_out),
        .result_ready_in    (result_ready_in),
        .result_channel_out (result_channel_out),
        .result_state_out   (result_state_out),
        .result_trials_out  (result_trials_out),
        .overrun_out        (overrun_out)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_bin(input int ch, input logic [BCW-1:0] v);
        bin_count_in[ch*BCW +: BCW] = v;
    endtask

    task automatic write_thr(input int addr, input logic [BCW-1:0] upper,
                             input logic [BCW-1:0] lower);
        thr_wr_en   = 1'b1;
        thr_wr_addr = TW'(addr);
        thr_wr_data = {upper, lower};
        tick();
        thr_wr_en   = 1'b0;
    endtask

    task automatic expect_result(input int ch, input logic st, input int tr);
        exp_t e;
        e.ch = CHW'(ch);
        e.st = st;
        e.tr = TW'(tr);
        sb_q.push_back(e);
    endtask

    task automatic drain();
        result_ready_in = 1'b1;
        for (int i = 0; i < 40 && sb_q.size() != 0; i++) tick();
        check("drain_queue_empty", 32'(sb_q.size()), 32'd0);
        tick();
        check("drain_valid_low", 32'(result_valid_out), 32'd0);
    endtask

    // Scoreboard monitor: a handshake seen here completes on the next rising edge.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && result_valid_out && result_ready_in) begin
            check("sb_entry_available", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check("sb_channel", 32'(result_channel_out), 32'(e.ch));
                check("sb_state",   32'(result_state_out),   32'(e.st));
                check("sb_trials",  32'(result_trials_out),  32'(e.tr));
            end
        end
    end

    initial begin
        rst             = 1'b1;
        thr_wr_en       = 1'b0;
        thr_wr_addr     = '0;
        thr_wr_data     = '0;
        max_trial_cfg   = TW'(2);
        start_in        = '0;
        finish_trial_in = '0;
        bin_count_in    = '0;
        result_ready_in = 1'b0;

        // ---------------- reset state ----------------
        tick();
        tick();
        check("rst_valid",   32'(result_valid_out),   32'd0);
        check("rst_fin",     32'(decision_fin_out),   32'd0);
        check("rst_overrun", 32'(overrun_out),        32'd0);
        check("rst_channel", 32'(result_channel_out), 32'd0);
        check("rst_state",   32'(result_state_out),   32'd0);
        check("rst_trials",  32'(result_trials_out),  32'd0);
        rst = 1'b0;

        // ---------------- T1: single-trial decision ----------------
        write_thr(0, 16'd100, 16'd20);
        result_ready_in = 1'b1;
        start_in = 4'b0001;
        tick();
        start_in = '0;
        set_bin(0, 16'd150);
        finish_trial_in = 4'b0001;
        settle();
        check("t1_fin", 32'(decision_fin_out), 32'h1);
        check("t1_valid_not_yet", 32'(result_valid_out), 32'd0);
        expect_result(0, 1'b1, 0);
        tick();
        finish_trial_in = '0;
        check("t1_valid", 32'(result_valid_out), 32'd1);
        check("t1_channel", 32'(result_channel_out), 32'd0);
        check("t1_trials", 32'(result_trials_out), 32'd0);
        drain();

        // ---------------- T2: multi-trial, fallback at last trial ----------------
        write_thr(1, 16'd100, 16'd20);
        write_thr(2, 16'd100, 16'd20);
        start_in = 4'b0001;
        tick();
        start_in = '0;
        finish_trial_in = 4'b0001;
        set_bin(0, 16'd50);
        settle();
        check("t2_fin_trial0", 32'(decision_fin_out), 32'h0);
        tick();
        set_bin(0, 16'd60);
        settle();
        check("t2_fin_trial1", 32'(decision_fin_out), 32'h0);
        tick();
        set_bin(0, 16'd40000);
        settle();
        check("t2_fin_trial2", 32'(decision_fin_out), 32'h1);
        expect_result(0, 1'b1, 2);
        tick();
        finish_trial_in = '0;
        drain();

        // T2b: fallback forces state 0 on ch3 with an in-between count
        start_in = 4'b1000;
        tick();
        start_in = '0;
        finish_trial_in = 4'b1000;
        set_bin(3, 16'd50);
        tick();
        tick();
        settle();
        check("t2b_fin_last", 32'(decision_fin_out), 32'h8);
        expect_result(3, 1'b0, 2);
        tick();
        finish_trial_in = '0;
        drain();

        // ---------------- T3: all channels decide at once, ready stalls ----------------
        start_in = 4'b1111;
        tick();
        start_in = '0;
        set_bin(0, 16'd100);
        set_bin(1, 16'd19);
        set_bin(2, 16'd200);
        set_bin(3, 16'd0);
        finish_trial_in = 4'b1111;
        settle();
        check("t3_fin_all", 32'(decision_fin_out), 32'hF);
        expect_result(0, 1'b1, 0);
        expect_result(1, 1'b0, 0);
        expect_result(2, 1'b1, 0);
        expect_result(3, 1'b0, 0);
        tick();
        finish_trial_in = '0;
        check("t3_first_ch0", 32'(result_channel_out), 32'd0);
        tick();
        check("t3_second_ch1", 32'(result_channel_out), 32'd1);
        tick();
        check("t3_third_ch2", 32'(result_channel_out), 32'd2);
        result_ready_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t3_stall_valid",   32'(result_valid_out),   32'd1);
            check("t3_stall_channel", 32'(result_channel_out), 32'd2);
            check("t3_stall_state",   32'(result_state_out),   32'd1);
            check("t3_stall_trials",  32'(result_trials_out),  32'd0);
        end
        drain();

        // ---------------- T4: overrun while pending ----------------
        result_ready_in = 1'b0;
        start_in = 4'b0010;
        tick();
        start_in = '0;
        set_bin(1, 16'd500);
        finish_trial_in = 4'b0010;
        settle();
        check("t4_fin", 32'(decision_fin_out), 32'h2);
        expect_result(1, 1'b1, 0);
        tick();
        finish_trial_in = '0;
        check("t4_no_overrun_yet", 32'(overrun_out), 32'h0);
        set_bin(1, 16'd5);
        finish_trial_in = 4'b0010;
        settle();
        check("t4_fin_in_pend", 32'(decision_fin_out), 32'h0);
        tick();
        finish_trial_in = '0;
        check("t4_overrun_set", 32'(overrun_out), 32'h2);
        check("t4_result_intact_state",  32'(result_state_out),  32'd1);
        check("t4_result_intact_trials", 32'(result_trials_out), 32'd0);
        drain();
        check("t4_overrun_sticky", 32'(overrun_out), 32'h2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t4_overrun_cleared", 32'(overrun_out), 32'h0);

        // ---------------- T5: write/read collision, start priority ----------------
        start_in = 4'b0100;
        tick();
        start_in = '0;
        set_bin(2, 16'd50);
        finish_trial_in = 4'b0100;
        settle();
        check("t5_fin_trial0", 32'(decision_fin_out), 32'h0);
        tick();
        thr_wr_en   = 1'b1;
        thr_wr_addr = TW'(1);
        thr_wr_data = {16'd40, 16'd10};
        settle();
        check("t5_old_thr_used", 32'(decision_fin_out), 32'h0);
        tick();
        thr_wr_en = 1'b0;
        start_in  = 4'b0100;
        set_bin(2, 16'd200);
        settle();
        check("t5_start_beats_finish", 32'(decision_fin_out), 32'h0);
        tick();
        start_in = '0;
        set_bin(2, 16'd50);
        settle();
        check("t5_restart_trial0", 32'(decision_fin_out), 32'h0);
        tick();
        settle();
        check("t5_new_thr_used", 32'(decision_fin_out), 32'h4);
        expect_result(2, 1'b1, 1);
        tick();
        finish_trial_in = '0;
        drain();

        // ---------------- T6: reset mid-measurement ----------------
        write_thr(3, 16'd100, 16'd20);
        max_trial_cfg   = TW'(4);
        result_ready_in = 1'b0;
        start_in = 4'b1001;
        tick();
        start_in = '0;
        set_bin(0, 16'd30);
        set_bin(3, 16'd1000);
        finish_trial_in = 4'b1001;
        settle();
        check("t6_fin_ch3", 32'(decision_fin_out), 32'h8);
        tick();
        finish_trial_in = 4'b0001;
        tick();
        tick();
        finish_trial_in = '0;
        check("t6_pre_rst_valid",   32'(result_valid_out),   32'd1);
        check("t6_pre_rst_channel", 32'(result_channel_out), 32'd3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_rst_valid",   32'(result_valid_out),   32'd0);
        check("t6_rst_channel", 32'(result_channel_out), 32'd0);
        check("t6_rst_fin",     32'(decision_fin_out),   32'h0);
        set_bin(0, 16'd1000);
        finish_trial_in = 4'b0001;
        settle();
        check("t6_idle_ignores_finish", 32'(decision_fin_out), 32'h0);
        tick();
        finish_trial_in = '0;
        check("t6_idle_no_valid", 32'(result_valid_out), 32'd0);
        result_ready_in = 1'b1;
        start_in = 4'b1001;
        tick();
        start_in = '0;
        set_bin(0, 16'd500);
        set_bin(3, 16'd5);
        finish_trial_in = 4'b1001;
        settle();
        check("t6_fin_ch0_ch3", 32'(decision_fin_out), 32'h9);
        expect_result(0, 1'b1, 0);
        expect_result(3, 1'b0, 0);
        tick();
        finish_trial_in = '0;
        check("t6_rr_restart_ch0", 32'(result_channel_out), 32'd0);
        drain();

        // ---------------- T7: max_trial_cfg lowered below trial_cnt ----------------
        start_in = 4'b0010;
        tick();
        start_in = '0;
        set_bin(1, 16'd30);
        finish_trial_in = 4'b0010;
        tick();
        tick();
        max_trial_cfg = TW'(1);
        settle();
        check("t7_forced_last", 32'(decision_fin_out), 32'h2);
        expect_result(1, 1'b0, 2);
        tick();
        finish_trial_in = '0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
